prog_clk_divider: RTL

Multi-channel programmable clock/tick generator, successor to the fixed single-output divider. Each of CHANNELS independent channels divides clk_in by a runtime-loadable divisor and produces either a square clock (toggle mode) or a one-cycle strobe (pulse mode). Divisor and mode are written through a valid/ready config port and applied glitch-free at the channel's next terminal count. It sits beside the game/display logic and supplies slow enables (e.g. 4 Hz) from the 100 MHz board clock.

---
 rtl/prog_clk_divider.sv | 123 ++++++++++++
 1 files changed

// File: rtl/prog_clk_divider.sv
// Multi-channel programmable divider: each channel emits a square clock (toggle
// mode) or a one-cycle strobe (pulse mode) from clk_in, reprogrammable at runtime.
module prog_clk_divider #(
  parameter int CHANNELS    = 4,
  parameter int WIDTH       = 24,
  parameter int DEFAULT_DIV = 12500000,
  localparam int CW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk_in,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] enable,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CW-1:0]       cfg_chan,
  input  logic [WIDTH-1:0]    cfg_div,
  input  logic                cfg_mode,
  output logic                cfg_err,
  output logic [CHANNELS-1:0] clk_out,
  output logic [CHANNELS-1:0] tick
);

  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);

  logic [WIDTH-1:0]    cnt [CHANNELS];
  logic [WIDTH-1:0]    div [CHANNELS];
  logic [CHANNELS-1:0] mode;

  logic                pend_vld;
  logic [CW-1:0]       pend_chan;
  logic [WIDTH-1:0]    pend_div;
  logic                pend_mode;

  logic [CHANNELS-1:0] term;
  logic [CHANNELS-1:0] apply;
  logic                apply_any;
  logic                accept;
  logic                bad_cfg;

  // A pending write lands only at a terminal count or while the channel is idle,
  // so the running period always completes before the new divisor takes over.
  always_comb begin
    term  = '0;
    apply = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      term[i]  = enable[i] && (cnt[i] == div[i] - ONE);
      apply[i] = pend_vld && (pend_chan == CW'(i)) && (term[i] || !enable[i]);
    end
  end

  assign apply_any = |apply;
  assign accept    = cfg_valid && cfg_ready;
  assign bad_cfg   = (cfg_div == '0) || (int'(cfg_chan) >= CHANNELS);

  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      pend_vld  <= 1'b0;
      cfg_ready <= 1'b1;
      cfg_err   <= 1'b0;
    end else begin
      cfg_err <= accept && bad_cfg;
      if (accept && !bad_cfg) begin
        pend_vld  <= 1'b1;
        cfg_ready <= 1'b0;
      end else if (apply_any) begin
        pend_vld  <= 1'b0;
        cfg_ready <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (accept && !bad_cfg) begin
      pend_chan <= cfg_chan;
      pend_div  <= cfg_div;
      pend_mode <= cfg_mode;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt[i]     <= '0;
        div[i]     <= DIV_RST;
        mode[i]    <= 1'b0;
        clk_out[i] <= 1'b0;
        tick[i]    <= 1'b0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (!enable[i]) begin
          tick[i] <= 1'b0;
          if (apply[i]) begin
            div[i]     <= pend_div;
            mode[i]    <= pend_mode;
            cnt[i]     <= '0;
            clk_out[i] <= 1'b0;
          end else if (mode[i]) begin
            clk_out[i] <= 1'b0;
          end
        end else if (term[i]) begin
          cnt[i]  <= '0;
          tick[i] <= 1'b1;
          // The terminal event that applies a write already follows the new mode.
          if (apply[i]) begin
            div[i]     <= pend_div;
            mode[i]    <= pend_mode;
            clk_out[i] <= pend_mode ? 1'b1 : ~clk_out[i];
          end else begin
            clk_out[i] <= mode[i] ? 1'b1 : ~clk_out[i];
          end
        end else begin
          cnt[i]  <= cnt[i] + ONE;
          tick[i] <= 1'b0;
          if (mode[i]) begin
            clk_out[i] <= 1'b0;
          end
        end
      end
    end
  end

endmodule
